// File: rtl/d_pop_arbiter_if.sv
// Bundle between d_pop_arbiter and its D0/D1 FIFOs plus the downstream valid/ready channel.
// Optional POP_STATS_EN adds the per-source delivery counters.
interface d_pop_arbiter_if #(
  parameter int DATA_WIDTH = 6
);
  logic                  enable;
  logic                  empty_fifo_D0;
  logic                  empty_fifo_D1;
  logic [DATA_WIDTH-1:0] data_out_D0;
  logic [DATA_WIDTH-1:0] data_out_D1;
  logic                  out_ready;
  logic                  D0_pop;
  logic                  D1_pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  src_out;
  logic                  busy;
`ifdef POP_STATS_EN
  logic [7:0]            count_D0;
  logic [7:0]            count_D1;
`endif

  // Arbiter side: consumes FIFO flags/data, drives pops and the output channel.
  modport master (
    input  enable, empty_fifo_D0, empty_fifo_D1, data_out_D0, data_out_D1, out_ready,
    output D0_pop, D1_pop, data_out, valid_out, src_out, busy
`ifdef POP_STATS_EN
    , output count_D0, count_D1
`endif
  );

  modport slave (
    output enable, empty_fifo_D0, empty_fifo_D1, data_out_D0, data_out_D1, out_ready,
    input  D0_pop, D1_pop, data_out, valid_out, src_out, busy
`ifdef POP_STATS_EN
    , input count_D0, count_D1
`endif
  );
endinterface

// File: rtl/d_pop_arbiter.sv
// Weighted round-robin drain of FIFOs D0/D1 onto one registered valid/ready output.
// Latency: pop in cycle N, valid_out from N+2; one word per 3 cycles when out_ready stays high.
// Backpressure: a word holds in data_out until out_ready; no new pop while it waits. Macro POP_STATS_EN adds counters.
module d_pop_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int BURST      = 4
) (
  input  logic            clk,
  input  logic            reset,
  d_pop_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, POP, CAPT, HOLD} state_t;

  localparam logic [3:0] BURST_C = 4'(BURST);

  state_t                state_q, state_d;
  logic                  grant_q, grant_d;
  logic [3:0]            burst_cnt_q, burst_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  src_q, src_d;
  logic                  valid_q, valid_d;

  logic                  any_rdy;
  logic                  accept;
  logic                  arb_go;
  logic                  arb_grant;
  logic [3:0]            arb_cnt;
  logic                  pop0, pop1;

  assign any_rdy = !bus.empty_fifo_D0 || !bus.empty_fifo_D1;
  assign accept  = (state_q == HOLD) && bus.out_ready;
  // Empty flags only matter in the two arbitration points: IDLE, or HOLD on accept.
  assign arb_go  = bus.enable && any_rdy && ((state_q == IDLE) || accept);

  always_comb begin
    arb_grant = grant_q;
    arb_cnt   = 4'd1;
    if (!bus.empty_fifo_D0 && !bus.empty_fifo_D1) begin
      if (burst_cnt_q >= BURST_C)
        arb_grant = ~grant_q;
    end else if (!bus.empty_fifo_D0) begin
      arb_grant = 1'b0;
    end else if (!bus.empty_fifo_D1) begin
      arb_grant = 1'b1;
    end
    if (arb_grant == grant_q)
      arb_cnt = (burst_cnt_q >= BURST_C) ? BURST_C : burst_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      burst_cnt_q <= 4'd0;
      data_q      <= '0;
      src_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      data_q      <= data_d;
      src_q       <= src_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_go) state_d = POP;
      POP:     state_d = CAPT;
      CAPT:    state_d = HOLD;
      HOLD:    if (accept) state_d = arb_go ? POP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    data_d      = data_q;
    src_d       = src_q;
    valid_d     = valid_q;
    pop0        = 1'b0;
    pop1        = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_go) begin
          grant_d     = arb_grant;
          burst_cnt_d = arb_cnt;
        end
      end
      POP: begin
        // Unconditional: non-empty was confirmed when the grant was latched.
        pop0 = !grant_q;
        pop1 = grant_q;
      end
      CAPT: begin
        data_d  = grant_q ? bus.data_out_D1 : bus.data_out_D0;
        src_d   = grant_q;
        valid_d = 1'b1;
      end
      HOLD: begin
        if (accept) begin
          valid_d = 1'b0;
          if (arb_go) begin
            grant_d     = arb_grant;
            burst_cnt_d = arb_cnt;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.D0_pop    = pop0;
  assign bus.D1_pop    = pop1;
  assign bus.data_out  = data_q;
  assign bus.src_out   = src_q;
  assign bus.valid_out = valid_q;
  assign bus.busy      = (state_q != IDLE);

`ifdef POP_STATS_EN
  logic [7:0] count_d0_q, count_d1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_d0_q <= 8'd0;
      count_d1_q <= 8'd0;
    end else if (accept) begin
      if (src_q) count_d1_q <= count_d1_q + 8'd1;
      else       count_d0_q <= count_d0_q + 8'd1;
    end
  end

  assign bus.count_D0 = count_d0_q;
  assign bus.count_D1 = count_d1_q;
`endif

endmodule

// File: tb/tb_d_pop_arbiter.sv
// Scoreboard bench for d_pop_arbiter: directed FIFO loads push expected {src,data}; a negedge monitor checks.
// Honours POP_STATS_EN when the design is built with it.
module tb_d_pop_arbiter;
  localparam int DW = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  d_pop_arbiter_if #(.DATA_WIDTH(DW)) ifc();
  d_pop_arbiter #(.DATA_WIDTH(DW), .BURST(4)) dut (.clk(clk), .reset(reset), .bus(ifc));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pop_count = 0;
  int last_pop_cyc = 0;

  logic [DW-1:0] f0[$];
  logic [DW-1:0] f1[$];
  logic [DW:0]   exp_q[$];

  logic          prev_valid = 1'b0, prev_ready = 1'b0, prev_pop = 1'b0, prev_src = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO models: read data appears the cycle after a pop.
  always @(posedge clk) begin
    if (!reset) begin
      if (ifc.D0_pop) begin
        check("pop_d0_nonempty", (f0.size() != 0), 1);
        if (f0.size() != 0) ifc.data_out_D0 <= f0.pop_front();
      end
      if (ifc.D1_pop) begin
        check("pop_d1_nonempty", (f1.size() != 0), 1);
        if (f1.size() != 0) ifc.data_out_D1 <= f1.pop_front();
      end
    end
    ifc.empty_fifo_D0 <= (f0.size() == 0);
    ifc.empty_fifo_D1 <= (f1.size() == 0);
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (reset) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_pop   = 1'b0;
    end else begin
      if (ifc.D0_pop || ifc.D1_pop) begin
        check("pop_exclusive", {31'd0, ifc.D0_pop & ifc.D1_pop}, 0);
        check("pop_while_valid", {31'd0, ifc.valid_out}, 0);
        check("pop_one_cycle", {31'd0, prev_pop}, 0);
        last_pop_cyc = cyc;
        pop_count++;
      end
      if (ifc.valid_out && !prev_valid)
        check("pop_to_valid", cyc - last_pop_cyc, 2);
      if (prev_valid && !prev_ready) begin
        check("stall_valid", {31'd0, ifc.valid_out}, 1);
        check("stall_data", ifc.data_out, prev_data);
        check("stall_src", {31'd0, ifc.src_out}, {31'd0, prev_src});
      end
      if (ifc.valid_out && ifc.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got data 0x%0h src %0d, expected no word", ifc.data_out, ifc.src_out);
        end else begin
          e = exp_q.pop_front();
          check("word_data", ifc.data_out, e[DW-1:0]);
          check("word_src", {31'd0, ifc.src_out}, {31'd0, e[DW]});
        end
      end
      prev_valid = ifc.valid_out;
      prev_ready = ifc.out_ready;
      prev_data  = ifc.data_out;
      prev_src   = ifc.src_out;
      prev_pop   = ifc.D0_pop | ifc.D1_pop;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    check("sb_drained", exp_q.size(), 0);
    reset = 1'b1;
    f0.delete();
    f1.delete();
    exp_q.delete();
    tick(2);
    check("rst_D0_pop", {31'd0, ifc.D0_pop}, 0);
    check("rst_D1_pop", {31'd0, ifc.D1_pop}, 0);
    check("rst_data_out", ifc.data_out, 0);
    check("rst_valid_out", {31'd0, ifc.valid_out}, 0);
    check("rst_src_out", {31'd0, ifc.src_out}, 0);
    check("rst_busy", {31'd0, ifc.busy}, 0);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && !ifc.busy && !ifc.valid_out) && n < budget) begin
      tick(1);
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: %0d words outstanding, expected 0 within %0d cycles", name, exp_q.size(), budget);
    end
  endtask

  task automatic wait_pop(input string name, input int budget);
    int n = 0;
    while (!(ifc.D0_pop || ifc.D1_pop) && n < budget) begin
      tick(1);
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no pop, expected one within %0d cycles", name, budget);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    reset = 1'b1;
    ifc.enable = 1'b0;
    ifc.out_ready = 1'b0;
    tick(1);

    // 1: single D0 word.
    do_reset();
    ifc.enable = 1'b1;
    ifc.out_ready = 1'b1;
    p = pop_count;
    f0.push_back(6'h15);
    exp_q.push_back({1'b0, 6'h15});
    wait_idle("t1", 50);
    tick(2);
    check("t1_pops", pop_count - p, 1);
    check("t1_idle", {31'd0, ifc.busy}, 0);

    // 2: both FIFOs with 6 words, BURST=4 -> D0x4, D1x4, D0x2, D1x2.
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      f0.push_back(DW'(i));
      f1.push_back(DW'(32 + i));
    end
    for (int i = 1; i <= 4; i++) exp_q.push_back({1'b0, DW'(i)});
    for (int i = 1; i <= 4; i++) exp_q.push_back({1'b1, DW'(32 + i)});
    for (int i = 5; i <= 6; i++) exp_q.push_back({1'b0, DW'(i)});
    for (int i = 5; i <= 6; i++) exp_q.push_back({1'b1, DW'(32 + i)});
    wait_idle("t2", 200);

    // 3: stalled output holds its word.
    do_reset();
    ifc.out_ready = 1'b0;
    f0.push_back(6'h2A);
    exp_q.push_back({1'b0, 6'h2A});
    for (int n = 0; n < 30 && !ifc.valid_out; n++) tick(1);
    check("t3_valid_rise", {31'd0, ifc.valid_out}, 1);
    p = pop_count;
    tick(5);
    check("t3_hold_valid", {31'd0, ifc.valid_out}, 1);
    check("t3_hold_data", ifc.data_out, 6'h2A);
    check("t3_no_pops", pop_count - p, 0);
    ifc.out_ready = 1'b1;
    wait_idle("t3", 20);

    // 4: enable drops during CAPT; in-flight word still delivered.
    do_reset();
    f0.push_back(6'h11);
    f1.push_back(6'h31);
    exp_q.push_back({1'b0, 6'h11});
    wait_pop("t4", 20);
    tick(1);
    ifc.enable = 1'b0;
    wait_idle("t4a", 20);
    p = pop_count;
    tick(6);
    check("t4_busy_low", {31'd0, ifc.busy}, 0);
    check("t4_no_pops", pop_count - p, 0);
    check("t4_d1_kept", f1.size(), 1);
    exp_q.push_back({1'b1, 6'h31});
    ifc.enable = 1'b1;
    wait_idle("t4b", 30);

    // 5: reset during POP drops the word and restarts granting D0.
    do_reset();
    f0.push_back(6'h07);
    wait_pop("t5", 20);
    #2;
    reset = 1'b1;
    #1;
    check("t5_D0_pop", {31'd0, ifc.D0_pop}, 0);
    check("t5_D1_pop", {31'd0, ifc.D1_pop}, 0);
    check("t5_valid", {31'd0, ifc.valid_out}, 0);
    check("t5_busy", {31'd0, ifc.busy}, 0);
    tick(1);
    do_reset();
    f0.push_back(6'h08);
    f1.push_back(6'h28);
    exp_q.push_back({1'b0, 6'h08});
    exp_q.push_back({1'b1, 6'h28});
    wait_idle("t5", 40);

`ifdef POP_STATS_EN
    // 6: delivery counters and wrap.
    do_reset();
    f0.push_back(6'h01); f0.push_back(6'h02); f0.push_back(6'h03);
    f1.push_back(6'h21); f1.push_back(6'h22);
    exp_q.push_back({1'b0, 6'h01});
    exp_q.push_back({1'b0, 6'h02});
    exp_q.push_back({1'b0, 6'h03});
    exp_q.push_back({1'b1, 6'h21});
    exp_q.push_back({1'b1, 6'h22});
    wait_idle("t6", 80);
    check("t6_count_D0", ifc.count_D0, 3);
    check("t6_count_D1", ifc.count_D1, 2);
    do_reset();
    for (int i = 0; i < 256; i++) begin
      f0.push_back(DW'(i));
      exp_q.push_back({1'b0, DW'(i)});
    end
    wait_idle("t6w", 1200);
    check("t6_wrap_D0", ifc.count_D0, 0);
    check("t6_wrap_D1", ifc.count_D1, 0);
`endif

    tick(2);
    check("sb_final", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/d_pop_arbiter.md
# d_pop_arbiter

Drain controller for the two output FIFOs (D0, D1) of the transmit-layer full_logic datapath. It generates `D0_pop`/`D1_pop` from the FIFO empty flags. It merges both FIFOs onto one registered output channel with a valid/ready handshake. A weighted round-robin arbiter decides which FIFO is read, with at most one word in flight.

## Interface
- `DATA_WIDTH`, 6: word width of D0/D1 FIFOs and of the output.
- `BURST`, 4: max consecutive grants to one FIFO while the other is non-empty (1..15).

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  permits new pops; in-flight word always completes.
- `empty_fifo_D0`  in  1  D0 FIFO empty flag.
- `empty_fifo_D1`  in  1  D1 FIFO empty flag.
- `data_out_D0`  in  DATA_WIDTH  D0 FIFO read data, valid the cycle after `D0_pop`.
- `data_out_D1`  in  DATA_WIDTH  D1 FIFO read data, valid the cycle after `D1_pop`.
- `out_ready`  in  1  downstream accepts word when high with `valid_out`.
- `D0_pop`  out  1  one-cycle pop strobe to D0.
- `D1_pop`  out  1  one-cycle pop strobe to D1.
- `data_out`  out  DATA_WIDTH  registered output word.
- `valid_out`  out  1  `data_out` holds a word.
- `src_out`  out  1  source of `data_out`: 0 = D0, 1 = D1.
- `busy`  out  1  state != IDLE.

## Operation
- FSM states are IDLE, POP, CAPT and HOLD. The reset state is IDLE.
- IDLE: if `enable` and either FIFO is non-empty, latch `grant` per the arbitration rule, then go to POP. Otherwise stay in IDLE.
- POP: assert `D<grant>_pop` for exactly this cycle, then go to CAPT. The pop is unconditional because non-empty was checked when the grant was made.
- CAPT: register `data_out_D<grant>` into `data_out` and `grant` into `src_out`, set `valid_out`, then go to HOLD.
- HOLD: keep `valid_out` = 1 and `data_out` stable until `out_ready` is high.
  - On accept with `enable` high and either FIFO non-empty: clear `valid_out`, arbitrate, go to POP.
  - On accept otherwise: clear `valid_out`, go to IDLE.
- Arbitration (`grant`, `burst_cnt` 4-bit):
  - Only one FIFO non-empty: grant it.
  - Both non-empty: keep the current `grant` if `burst_cnt` < BURST, else switch.
  - Keeping the grant increments `burst_cnt`, saturating at BURST. Switching sets `burst_cnt` = 1.
  - Both non-empty right after reset: grant D0.
- `D0_pop` and `D1_pop` are never high in the same cycle. A pop is never issued while the sampled empty flag is 1.
- `enable` falling mid-transfer does not abort the word; the FSM returns to IDLE after the accept.

## Timing
- Reset values: `D0_pop`=0, `D1_pop`=0, `data_out`=0, `valid_out`=0, `src_out`=0, `busy`=0. Also `grant`=0 and `burst_cnt`=0.
- Reset asserted mid-operation clears all state immediately, including a pop strobe in flight; the word in flight is lost.
- Pop-to-valid latency: pop in cycle N, data captured at the end of N+1, `valid_out` high from N+2.
- Back-to-back throughput with `out_ready` tied high: one word per 3 cycles (POP, CAPT, HOLD).
- `valid_out` does not drop without an accept. `data_out`/`src_out` do not change while `valid_out`=1 and `out_ready`=0.
- The empty flags are sampled only in the arbitration cycle (IDLE, or HOLD on accept).

## Configuration
- `POP_STATS_EN` defined: adds outputs `count_D0` and `count_D1` (8 bits each).
  - Each counts words delivered per source, incrementing on accept.
  - Counters wrap at 255→0 and reset to 0.
- `POP_STATS_EN` undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset, then D0 holds 0x15 and D1 is empty, `out_ready`=1, `enable`=1 → `D0_pop` one cycle. `data_out`=0x15 and `src_out`=0 two cycles later. Back to IDLE.
- D0 holds 6 words and D1 holds 6 words, BURST=4, `out_ready`=1 → source order D0×4, D1×4, D0×2, D1×2. No simultaneous pops.
- `out_ready`=0 for 5 cycles after `valid_out` rises, D0 holds 0x2A → `data_out`=0x2A stable with `valid_out`=1, no further pops. One accept on `out_ready`=1.
- `enable` dropped during CAPT with both FIFOs non-empty → current word delivered, then `busy`=0 and no pops until `enable`=1.
- `reset` asserted during POP → `D0_pop` and `D1_pop` low in the same cycle, all outputs at reset values, restart from IDLE granting D0.
- With `POP_STATS_EN`: 3 D0 words and 2 D1 words accepted → `count_D0`=3, `count_D1`=2. 256 D0 accepts → `count_D0` wraps to 0.
